ram_access_ctrl: RTL and testbench



---
 rtl/ram_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_ram_access_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: valid/ready front end for a bank of DEPTH 4-bit RAM cells.
// Each accepted command gets one ACCESS cycle that drives the cell strobes,
// then a RESP cycle that holds the response until the consumer takes it.
// A bank clear takes one CLEAR cycle and produces no response.
module ram_access_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 CLK,
  input  logic                 CLR_N,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_WR,
  input  logic [AW-1:0]        REQ_ADDR,
  input  logic [3:0]           REQ_DATA,
  input  logic                 CLR_REQ,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [3:0]           RSP_DATA,
  output logic                 RSP_ERR,
  output logic [DEPTH-1:0]     MEM_SEL,
  output logic                 MEM_R_W,
  output logic [3:0]           MEM_DIN,
  input  logic [4*DEPTH-1:0]   MEM_DOUT,
  output logic                 MEM_CLR
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DEPTH-1:0]   sel_q, sel_d;
  logic               r_w_q, r_w_d;
  logic [3:0]         din_q, din_d;
  logic               clr_q, clr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [3:0]         rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  // Addresses are widened to 32 bits so the unsigned compare against DEPTH
  // works even when DEPTH does not fit in AW bits.
  logic [31:0]        req_addr_ext;
  logic [31:0]        addr_ext;
  logic [DEPTH-1:0]   req_sel;
  logic [3:0]         rd_terms [DEPTH];
  logic [3:0]         rd_data;
  logic               in_range;

  assign req_addr_ext = 32'(REQ_ADDR);
  assign addr_ext     = 32'(addr_q);
  assign in_range     = (addr_ext < 32'(DEPTH));

  // One-hot decode and per-cell read masking; an out-of-range address simply
  // matches no cell, so the select is all zero and the read mux yields 0.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    assign req_sel[gi]  = (req_addr_ext == 32'(gi));
    assign rd_terms[gi] = (addr_ext == 32'(gi)) ? MEM_DOUT[4*gi +: 4] : 4'h0;
  end

  // OR-reduce the masked cell outputs into the read data word.
  always_comb begin
    rd_data = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_data = rd_data | rd_terms[i];
    end
  end

  assign REQ_READY = (state_q == IDLE) & ~CLR_REQ & CLR_N;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    r_w_d       = r_w_q;
    din_d       = din_q;
    clr_d       = clr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d = CLEAR;
          clr_d   = 1'b1;
          sel_d   = '0;
        end else if (REQ_VALID && REQ_READY) begin
          state_d = ACCESS;
          addr_d  = REQ_ADDR;
          sel_d   = req_sel;
          r_w_d   = ~REQ_WR;
          din_d   = REQ_WR ? REQ_DATA : 4'h0;
        end
      end
      ACCESS: begin
        // r_w_q still holds the command direction during this cycle.
        state_d     = RESP;
        sel_d       = '0;
        r_w_d       = 1'b1;
        din_d       = 4'h0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = ~in_range;
        rsp_data_d  = (r_w_q && in_range) ? rd_data : 4'h0;
      end
      RESP: begin
        if (RSP_READY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      CLEAR: begin
        state_d = IDLE;
        clr_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset to the idle levels.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sel_q       <= '0;
      r_w_q       <= 1'b1;
      din_q       <= 4'h0;
      clr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      r_w_q       <= r_w_d;
      din_q       <= din_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign MEM_SEL   = sel_q;
  assign MEM_R_W   = r_w_q;
  assign MEM_DIN   = din_q;
  assign MEM_CLR   = clr_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: instance A (DEPTH=4) for the main
// behaviour, instance B (DEPTH=3) for out-of-range addresses. Each instance
// is attached to a small behavioural model of the RAM cells.
module tb_ram_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  // Instance A signals (DEPTH=4)
  logic        req_valid_a = 0, req_wr_a = 0, clr_req_a = 0, rsp_ready_a = 0;
  logic [1:0]  req_addr_a = 0;
  logic [3:0]  req_data_a = 0;
  logic        req_ready_a, rsp_valid_a, rsp_err_a, mem_r_w_a, mem_clr_a;
  logic [3:0]  rsp_data_a, mem_din_a, mem_sel_a;
  logic [15:0] mem_dout_a = '0;
  logic [3:0]  cell_a [4];

  // Instance B signals (DEPTH=3)
  logic        req_valid_b = 0, req_wr_b = 0, clr_req_b = 0, rsp_ready_b = 0;
  logic [1:0]  req_addr_b = 0;
  logic [3:0]  req_data_b = 0;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, mem_r_w_b, mem_clr_b;
  logic [3:0]  rsp_data_b, mem_din_b;
  logic [2:0]  mem_sel_b;
  logic [11:0] mem_dout_b = '0;
  logic [3:0]  cell_b [3];

  ram_access_ctrl #(.DEPTH(4), .AW(2)) dut_a (
    .CLK(clk), .CLR_N(rst_n), .REQ_VALID(req_valid_a), .REQ_READY(req_ready_a),
    .REQ_WR(req_wr_a), .REQ_ADDR(req_addr_a), .REQ_DATA(req_data_a),
    .CLR_REQ(clr_req_a), .RSP_VALID(rsp_valid_a), .RSP_READY(rsp_ready_a),
    .RSP_DATA(rsp_data_a), .RSP_ERR(rsp_err_a), .MEM_SEL(mem_sel_a),
    .MEM_R_W(mem_r_w_a), .MEM_DIN(mem_din_a), .MEM_DOUT(mem_dout_a),
    .MEM_CLR(mem_clr_a)
  );

  ram_access_ctrl #(.DEPTH(3), .AW(2)) dut_b (
    .CLK(clk), .CLR_N(rst_n), .REQ_VALID(req_valid_b), .REQ_READY(req_ready_b),
    .REQ_WR(req_wr_b), .REQ_ADDR(req_addr_b), .REQ_DATA(req_data_b),
    .CLR_REQ(clr_req_b), .RSP_VALID(rsp_valid_b), .RSP_READY(rsp_ready_b),
    .RSP_DATA(rsp_data_b), .RSP_ERR(rsp_err_b), .MEM_SEL(mem_sel_b),
    .MEM_R_W(mem_r_w_b), .MEM_DIN(mem_din_b), .MEM_DOUT(mem_dout_b),
    .MEM_CLR(mem_clr_b)
  );

  // RAM cell models: write on rising clock, clear on MEM_CLR rising, drive
  // data on falling clock when selected for read.
  always @(posedge clk or posedge mem_clr_a) begin
    if (mem_clr_a) begin
      for (int i = 0; i < 4; i++) cell_a[i] <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_sel_a[i] && !mem_r_w_a) cell_a[i] <= mem_din_a;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_sel_a[i] && mem_r_w_a) mem_dout_a[4*i +: 4] <= cell_a[i];
  end
  always @(posedge clk or posedge mem_clr_b) begin
    if (mem_clr_b) begin
      for (int i = 0; i < 3; i++) cell_b[i] <= 4'h0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (mem_sel_b[i] && !mem_r_w_b) cell_b[i] <= mem_din_b;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (mem_sel_b[i] && mem_r_w_b) mem_dout_b[4*i +: 4] <= cell_b[i];
  end

  // Present a command and return 1 ns after the edge that accepts it.
  task automatic send(input bit b, input logic wr, input logic [1:0] addr,
                      input logic [3:0] data);
    int k;
    $display("[TB] cmd inst=%s wr=%0b addr=%0d data=%h", b ? "B" : "A", wr, addr, data);
    if (!b) begin
      req_wr_a = wr; req_addr_a = addr; req_data_a = data; req_valid_a = 1'b1;
    end else begin
      req_wr_b = wr; req_addr_b = addr; req_data_b = data; req_valid_b = 1'b1;
    end
    #1;
    k = 0;
    while (!(b ? req_ready_b : req_ready_a) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: req_ready got 0 required 1");
    end
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  // Accept the outstanding response and wait until the controller is idle.
  task automatic drain(input bit b);
    int k;
    rsp_ready_a = 1'b1;
    rsp_ready_b = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(b ? req_ready_b : req_ready_a) && k < 20);
    if (k >= 20) begin
      tests_run++; tests_failed++;
      $display("FAIL drain_timeout: req_ready got 0 required 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready_a !== 1'b0) begin tests_failed++; $display("FAIL rst_req_ready: got %b required 0", req_ready_a); end
    tests_run++; if (rsp_valid_a !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid_a); end
    tests_run++; if (rsp_data_a !== 4'h0) begin tests_failed++; $display("FAIL rst_rsp_data: got %h required 0", rsp_data_a); end
    tests_run++; if (rsp_err_a !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err_a); end
    tests_run++; if (mem_sel_a !== 4'b0000) begin tests_failed++; $display("FAIL rst_mem_sel: got %b required 0000", mem_sel_a); end
    tests_run++; if (mem_r_w_a !== 1'b1) begin tests_failed++; $display("FAIL rst_mem_r_w: got %b required 1", mem_r_w_a); end
    tests_run++; if (mem_din_a !== 4'h0) begin tests_failed++; $display("FAIL rst_mem_din: got %h required 0", mem_din_a); end
    tests_run++; if (mem_clr_a !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_clr: got %b required 0", mem_clr_a); end
    rst_n = 1'b1;
    rsp_ready_a = 1'b1;
    rsp_ready_b = 1'b1;
    @(negedge clk);
    tests_run++; if (req_ready_a !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b required 1", req_ready_a); end
  endtask

  task automatic test_write();
    send(1'b0, 1'b1, 2'd2, 4'hA);
    @(negedge clk);  // ACCESS
    tests_run++; if (mem_sel_a !== 4'b0100) begin tests_failed++; $display("FAIL wr_sel: got %b required 0100", mem_sel_a); end
    tests_run++; if (mem_r_w_a !== 1'b0) begin tests_failed++; $display("FAIL wr_r_w: got %b required 0", mem_r_w_a); end
    tests_run++; if (mem_din_a !== 4'hA) begin tests_failed++; $display("FAIL wr_din: got %h required a", mem_din_a); end
    tests_run++; if (req_ready_a !== 1'b0) begin tests_failed++; $display("FAIL wr_busy_ready: got %b required 0", req_ready_a); end
    @(negedge clk);  // RESP
    tests_run++; if (rsp_valid_a !== 1'b1) begin tests_failed++; $display("FAIL wr_rsp_valid: got %b required 1", rsp_valid_a); end
    tests_run++; if (rsp_data_a !== 4'h0) begin tests_failed++; $display("FAIL wr_rsp_data: got %h required 0", rsp_data_a); end
    tests_run++; if (rsp_err_a !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp_err: got %b required 0", rsp_err_a); end
    tests_run++; if (mem_sel_a !== 4'b0000) begin tests_failed++; $display("FAIL wr_sel_off: got %b required 0000", mem_sel_a); end
    tests_run++; if (mem_r_w_a !== 1'b1) begin tests_failed++; $display("FAIL wr_r_w_idle: got %b required 1", mem_r_w_a); end
    tests_run++; if (mem_din_a !== 4'h0) begin tests_failed++; $display("FAIL wr_din_idle: got %h required 0", mem_din_a); end
    @(negedge clk);  // back in IDLE after the handshake
    tests_run++; if (rsp_valid_a !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp_drop: got %b required 0", rsp_valid_a); end
    tests_run++; if (req_ready_a !== 1'b1) begin tests_failed++; $display("FAIL wr_ready_t2: got %b required 1", req_ready_a); end
  endtask

  task automatic test_readback();
    send(1'b0, 1'b1, 2'd1, 4'h5);
    drain(1'b0);
    send(1'b0, 1'b0, 2'd1, 4'hF);
    @(negedge clk);  // ACCESS
    tests_run++; if (mem_sel_a !== 4'b0010) begin tests_failed++; $display("FAIL rd_sel: got %b required 0010", mem_sel_a); end
    tests_run++; if (mem_r_w_a !== 1'b1) begin tests_failed++; $display("FAIL rd_r_w: got %b required 1", mem_r_w_a); end
    tests_run++; if (mem_din_a !== 4'h0) begin tests_failed++; $display("FAIL rd_din: got %h required 0", mem_din_a); end
    @(negedge clk);  // RESP
    tests_run++; if (rsp_data_a !== 4'h5) begin tests_failed++; $display("FAIL rd_data: got %h required 5", rsp_data_a); end
    tests_run++; if (rsp_err_a !== 1'b0) begin tests_failed++; $display("FAIL rd_err: got %b required 0", rsp_err_a); end
    tests_run++; if (mem_sel_a !== 4'b0000) begin tests_failed++; $display("FAIL rd_sel_off: got %b required 0000", mem_sel_a); end
    drain(1'b0);
    send(1'b0, 1'b0, 2'd2, 4'h0);
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (rsp_data_a !== 4'hA) begin tests_failed++; $display("FAIL rd_data_addr2: got %h required a", rsp_data_a); end
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    rsp_ready_a = 1'b0;
    send(1'b0, 1'b0, 2'd2, 4'h0);
    @(negedge clk);  // ACCESS
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);  // RESP, held
      tests_run++; if (rsp_valid_a !== 1'b1) begin tests_failed++; $display("FAIL bp_valid[%0d]: got %b required 1", i, rsp_valid_a); end
      tests_run++; if (rsp_data_a !== 4'hA) begin tests_failed++; $display("FAIL bp_data[%0d]: got %h required a", i, rsp_data_a); end
      tests_run++; if (req_ready_a !== 1'b0) begin tests_failed++; $display("FAIL bp_ready[%0d]: got %b required 0", i, req_ready_a); end
      tests_run++; if (mem_clr_a !== 1'b0) begin tests_failed++; $display("FAIL bp_clr_ignored[%0d]: got %b required 0", i, mem_clr_a); end
      clr_req_a = (i == 1);
    end
    clr_req_a = 1'b0;
    rsp_ready_a = 1'b1;
    req_valid_a = 1'b1; req_wr_a = 1'b0; req_addr_a = 2'd1;
    @(negedge clk);  // handshake happened; IDLE now
    tests_run++; if (rsp_valid_a !== 1'b0) begin tests_failed++; $display("FAIL bp_rsp_drop: got %b required 0", rsp_valid_a); end
    tests_run++; if (req_ready_a !== 1'b1) begin tests_failed++; $display("FAIL bp_next_ready: got %b required 1", req_ready_a); end
    tests_run++; if (mem_clr_a !== 1'b0) begin tests_failed++; $display("FAIL bp_no_clear: got %b required 0", mem_clr_a); end
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    @(negedge clk);  // ACCESS for the next command
    tests_run++; if (mem_sel_a !== 4'b0010) begin tests_failed++; $display("FAIL bp_next_sel: got %b required 0010", mem_sel_a); end
    @(negedge clk);
    tests_run++; if (rsp_data_a !== 4'h5) begin tests_failed++; $display("FAIL bp_next_data: got %h required 5", rsp_data_a); end
    drain(1'b0);
  endtask

  task automatic test_clear_priority();
    clr_req_a = 1'b1;
    req_valid_a = 1'b1; req_wr_a = 1'b0; req_addr_a = 2'd2;
    #1;
    tests_run++; if (req_ready_a !== 1'b0) begin tests_failed++; $display("FAIL clr_blocks_ready: got %b required 0", req_ready_a); end
    @(negedge clk);  // CLEAR
    tests_run++; if (mem_clr_a !== 1'b1) begin tests_failed++; $display("FAIL clr_pulse: got %b required 1", mem_clr_a); end
    tests_run++; if (mem_sel_a !== 4'b0000) begin tests_failed++; $display("FAIL clr_sel: got %b required 0000", mem_sel_a); end
    tests_run++; if (req_ready_a !== 1'b0) begin tests_failed++; $display("FAIL clr_state_ready: got %b required 0", req_ready_a); end
    clr_req_a = 1'b0;
    @(negedge clk);  // IDLE again, command still pending
    tests_run++; if (mem_clr_a !== 1'b0) begin tests_failed++; $display("FAIL clr_pulse_end: got %b required 0", mem_clr_a); end
    tests_run++; if (req_ready_a !== 1'b1) begin tests_failed++; $display("FAIL clr_ready_after: got %b required 1", req_ready_a); end
    tests_run++; if (rsp_valid_a !== 1'b0) begin tests_failed++; $display("FAIL clr_no_rsp: got %b required 0", rsp_valid_a); end
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    @(negedge clk);  // ACCESS
    tests_run++; if (mem_sel_a !== 4'b0100) begin tests_failed++; $display("FAIL clr_cmd_sel: got %b required 0100", mem_sel_a); end
    @(negedge clk);  // RESP
    tests_run++; if (rsp_data_a !== 4'h0) begin tests_failed++; $display("FAIL clr_read_zero: got %h required 0", rsp_data_a); end
    drain(1'b0);
    // CLR_REQ held: pulses separated by one low cycle
    clr_req_a = 1'b1;
    @(negedge clk);
    tests_run++; if (mem_clr_a !== 1'b1) begin tests_failed++; $display("FAIL clr_held_p1: got %b required 1", mem_clr_a); end
    @(negedge clk);
    tests_run++; if (mem_clr_a !== 1'b0) begin tests_failed++; $display("FAIL clr_held_gap: got %b required 0", mem_clr_a); end
    @(negedge clk);
    tests_run++; if (mem_clr_a !== 1'b1) begin tests_failed++; $display("FAIL clr_held_p2: got %b required 1", mem_clr_a); end
    clr_req_a = 1'b0;
    @(negedge clk);
    tests_run++; if (mem_clr_a !== 1'b0) begin tests_failed++; $display("FAIL clr_held_end: got %b required 0", mem_clr_a); end
  endtask

  task automatic test_out_of_range();
    send(1'b1, 1'b1, 2'd2, 4'h9);
    drain(1'b1);
    send(1'b1, 1'b0, 2'd3, 4'h0);
    @(negedge clk);  // ACCESS
    tests_run++; if (mem_sel_b !== 3'b000) begin tests_failed++; $display("FAIL oor_rd_sel: got %b required 000", mem_sel_b); end
    @(negedge clk);  // RESP
    tests_run++; if (rsp_valid_b !== 1'b1) begin tests_failed++; $display("FAIL oor_rd_valid: got %b required 1", rsp_valid_b); end
    tests_run++; if (rsp_err_b !== 1'b1) begin tests_failed++; $display("FAIL oor_rd_err: got %b required 1", rsp_err_b); end
    tests_run++; if (rsp_data_b !== 4'h0) begin tests_failed++; $display("FAIL oor_rd_data: got %h required 0", rsp_data_b); end
    @(negedge clk);  // IDLE
    tests_run++; if (rsp_err_b !== 1'b0) begin tests_failed++; $display("FAIL oor_err_clear: got %b required 0", rsp_err_b); end
    send(1'b1, 1'b1, 2'd3, 4'hF);
    @(negedge clk);
    tests_run++; if (mem_sel_b !== 3'b000) begin tests_failed++; $display("FAIL oor_wr_sel: got %b required 000", mem_sel_b); end
    @(negedge clk);
    tests_run++; if (rsp_err_b !== 1'b1) begin tests_failed++; $display("FAIL oor_wr_err: got %b required 1", rsp_err_b); end
    drain(1'b1);
    send(1'b1, 1'b0, 2'd2, 4'h0);
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (rsp_data_b !== 4'h9) begin tests_failed++; $display("FAIL oor_cell_kept: got %h required 9", rsp_data_b); end
    tests_run++; if (rsp_err_b !== 1'b0) begin tests_failed++; $display("FAIL oor_inrange_err: got %b required 0", rsp_err_b); end
    drain(1'b1);
  endtask

  task automatic test_reset_mid_resp();
    rsp_ready_a = 1'b0;
    send(1'b0, 1'b0, 2'd1, 4'h0);
    @(negedge clk);
    @(negedge clk);  // RESP
    tests_run++; if (rsp_valid_a !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_valid: got %b required 1", rsp_valid_a); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (rsp_valid_a !== 1'b0) begin tests_failed++; $display("FAIL mid_async_valid: got %b required 0", rsp_valid_a); end
    tests_run++; if (req_ready_a !== 1'b0) begin tests_failed++; $display("FAIL mid_async_ready: got %b required 0", req_ready_a); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (req_ready_a !== 1'b1) begin tests_failed++; $display("FAIL mid_ready[%0d]: got %b required 1", i, req_ready_a); end
      tests_run++; if (rsp_valid_a !== 1'b0) begin tests_failed++; $display("FAIL mid_stale[%0d]: got %b required 0", i, rsp_valid_a); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_backpressure();
    test_clear_priority();
    test_out_of_range();
    test_reset_mid_resp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
